// File: rtl/fpu_aligner.sv
// fpu_aligner: orders two IEEE-754 operands by magnitude and right-aligns the smaller mantissa with sticky tracking
module fpu_aligner #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [EXP_W+FRAC_W:0]     a,
  input  logic [EXP_W+FRAC_W:0]     b,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W-1:0]          exp_out,
  output logic [FRAC_W+3:0]         mant_big,
  output logic [FRAC_W+3:0]         mant_small,
  output logic                      sign_big,
  output logic                      sign_small,
  output logic                      swapped,
  output logic                      special
);
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 4;
  localparam int CW = $clog2(MW);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, k_nx;
  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff, diff;
  logic [MW-1:0] mant_a, mant_b;
  logic swap_nx, spec_nx, accept;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid & in_ready;
  // operand decode, magnitude ordering and clamped shift distance for the accept edge
  always_comb begin
    ea = a[W-2:FRAC_W];
    eb = b[W-2:FRAC_W];
    ea_eff = ea == '0 ? EXP_W'(1) : ea;
    eb_eff = eb == '0 ? EXP_W'(1) : eb;
    mant_a = {|ea, a[FRAC_W-1:0], 3'b000};
    mant_b = {|eb, b[FRAC_W-1:0], 3'b000};
    swap_nx = b[W-2:0] > a[W-2:0];
    spec_nx = &ea | &eb;
    diff = swap_nx ? eb_eff - ea_eff : ea_eff - eb_eff;
    k_nx = diff > EXP_W'(MW-1) ? CW'(MW-1) : CW'(diff);
  end
  // next state: zero shift or Inf/NaN skips SHIFT; DONE waits for the consumer
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? ((k_nx == '0 || spec_nx) ? DONE : SHIFT) : IDLE) :
               state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) :
               (out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // datapath: capture ordered operands on accept, then shift the small mantissa keeping the sticky bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      exp_out <= '0;
      mant_big <= '0;
      mant_small <= '0;
      sign_big <= 1'b0;
      sign_small <= 1'b0;
      swapped <= 1'b0;
      special <= 1'b0;
    end else if (accept) begin
      cnt <= k_nx;
      exp_out <= swap_nx ? eb_eff : ea_eff;
      mant_big <= swap_nx ? mant_b : mant_a;
      mant_small <= swap_nx ? mant_a : mant_b;
      sign_big <= swap_nx ? b[W-1] : a[W-1];
      sign_small <= swap_nx ? a[W-1] : b[W-1];
      swapped <= swap_nx;
      special <= spec_nx;
    end else if (state == SHIFT) begin
      cnt <= cnt - CW'(1);
      mant_small <= {1'b0, mant_small[MW-1:2], |mant_small[1:0]};
    end
  end
endmodule

// File: tb/tb_fpu_aligner.sv
// tb_fpu_aligner: directed vectors with a queue scoreboard checked by an independent output monitor
module tb_fpu_aligner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, sign_big, sign_small, swapped, special;
  logic [7:0] exp_out;
  logic [26:0] mant_big, mant_small;
  int n_checks = 0, n_fail = 0, cyc = 0;
  typedef struct {
    logic [7:0] ex;
    logic [26:0] mb, ms;
    logic sb, ss, sw, sp;
    int lat, acc;
  } exp_t;
  exp_t q[$];
  bit seen = 0;

  fpu_aligner dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out), .mant_big(mant_big),
    .mant_small(mant_small), .sign_big(sign_big), .sign_small(sign_small),
    .swapped(swapped), .special(special)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: first cycle of each out_valid pops and checks the oldest expectation
  always @(negedge clk) begin
    if (!out_valid) seen = 0;
    else if (!seen) begin
      seen = 1;
      if (q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("exp_out", {24'd0, exp_out}, {24'd0, e.ex});
        check("mant_big", {5'd0, mant_big}, {5'd0, e.mb});
        check("mant_small", {5'd0, mant_small}, {5'd0, e.ms});
        check("sign_big", {31'd0, sign_big}, {31'd0, e.sb});
        check("sign_small", {31'd0, sign_small}, {31'd0, e.ss});
        check("swapped", {31'd0, swapped}, {31'd0, e.sw});
        check("special", {31'd0, special}, {31'd0, e.sp});
        check("latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic start_op(input logic [31:0] ai, bi, input logic [7:0] ex, input logic [26:0] mb, ms,
                          input logic sb, ss, sw, sp, input int lat);
    exp_t e;
    @(negedge clk);
    a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.ex = ex; e.mb = mb; e.ms = ms; e.sb = sb; e.ss = ss; e.sw = sw; e.sp = sp;
    e.lat = lat; e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_valid;
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = out_valid;
    end
    if (!done) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_op;
    wait_valid();
    @(posedge clk); #1;
    check("in_ready_after_done", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic op(input logic [31:0] ai, bi, input logic [7:0] ex, input logic [26:0] mb, ms,
                    input logic sb, ss, sw, sp, input int lat);
    start_op(ai, bi, ex, mb, ms, sb, ss, sw, sp, lat);
    finish_op();
  endtask

  task automatic check_zero_outputs;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_exp_out", {24'd0, exp_out}, 32'd0);
    check("rst_mant_big", {5'd0, mant_big}, 32'd0);
    check("rst_mant_small", {5'd0, mant_small}, 32'd0);
    check("rst_swapped", {31'd0, swapped}, 32'd0);
    check("rst_special", {31'd0, special}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    op(32'h40000000, 32'h3F800000, 8'h80, 27'h4000000, 27'h2000000, 0, 0, 0, 0, 2);
    op(32'hBF800000, 32'h40000000, 8'h80, 27'h4000000, 27'h2000000, 0, 1, 1, 0, 2);
    op(32'h3F800000, 32'h3F800000, 8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0, 0, 1);
    op(32'h4B800000, 32'h3F800001, 8'h97, 27'h4000000, 27'h0000005, 0, 0, 0, 0, 25);
    op(32'h7F000000, 32'h3F800000, 8'hFE, 27'h4000000, 27'h0000001, 0, 0, 0, 0, 27);
    op(32'h7F800000, 32'h3F800000, 8'hFF, 27'h4000000, 27'h4000000, 0, 0, 0, 1, 1);
    op(32'h00000001, 32'h00800000, 8'h01, 27'h4000000, 27'h0000008, 0, 0, 1, 0, 1);
    op(32'hC0000000, 32'h40000000, 8'h80, 27'h4000000, 27'h4000000, 1, 0, 0, 0, 1);
    // consumer stall: outputs hold and new operands are refused
    out_ready = 1'b0;
    start_op(32'h40000000, 32'h3F800000, 8'h80, 27'h4000000, 27'h2000000, 0, 0, 0, 0, 2);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a = 32'h7F800000; b = 32'h00000001; in_valid = (i % 2) == 0;
      @(negedge clk);
      check("hold_exp_out", {24'd0, exp_out}, 32'h80);
      check("hold_mant_small", {5'd0, mant_small}, 32'h2000000);
      check("hold_special", {31'd0, special}, 32'd0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("no_ghost_op", {31'd0, out_valid}, 32'd0);
    end
    // reset in the middle of a long shift, with operands offered during reset
    start_op(32'h4B800000, 32'h3F800001, 8'h97, 27'h4000000, 27'h0000005, 0, 0, 0, 0, 25);
    repeat (9) @(posedge clk);
    @(negedge clk);
    q.delete();
    rst_n = 1'b0;
    a = 32'h40000000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", {31'd0, out_valid}, 32'd0);
    end
    op(32'h40000000, 32'h3F800000, 8'h80, 27'h4000000, 27'h2000000, 0, 0, 0, 0, 2);
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_aligner.md
FPU_ALIGNER -- requirements
Module: fpu_aligner

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter FRAC_W, default 23, fraction field width; operand width = 1+EXP_W+FRAC_W (32 at defaults).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 a, b  input  32  IEEE-754 single operands.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept operands (high only in IDLE).
REQ-008 out_valid  output  1  aligned result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 exp_out  output  8  larger exponent (effective, see REQ-016).
REQ-011 mant_big, mant_small  output  27 each  {hidden bit, 23-bit fraction, G, R, S} of larger and aligned smaller operand.
REQ-012 sign_big, sign_small  output  1 each  signs of larger and smaller operand.
REQ-013 swapped  output  1  high when |b| > |a|.
REQ-014 special  output  1  high when either operand has exponent 255 (Inf/NaN).

Function
REQ-015 FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Per operand: hidden bit = (exp!=0); effective exponent = exp, or 1 when exp==0 (denormal).
REQ-017 On in_valid && in_ready: order by magnitude {exp,frac}; tie -> a is big, swapped=0; register big/small fields, mant = {hidden,frac,3'b000}.
REQ-018 Shift count k = min(exp_big_eff - exp_small_eff, 26), computed at accept; difference is non-negative by construction.
REQ-019 If k==0 or special==1: IDLE -> DONE at accept edge, no shifting; out_valid high 1 cycle after accept.
REQ-020 Else IDLE -> SHIFT; each SHIFT cycle: mant_small shifted right 1, new S = old S | bit shifted out of S position, k decremented; SHIFT -> DONE when k reaches 0 on that edge.
REQ-021 Latency accept edge -> out_valid = 1 + k cycles (max 27).
REQ-022 Sticky invariant: S = OR of all bits shifted out of the 27-bit word.
REQ-023 In DONE all outputs held stable until out_valid && out_ready; then DONE -> IDLE, in_ready high next cycle.
REQ-024 in_valid ignored outside IDLE; no overlap of two operations.
REQ-025 Data outputs undefined-free: hold last computed values in IDLE/SHIFT; only meaningful while out_valid.

Reset
REQ-026 rst_n low at clk edge -> state IDLE, out_valid=0, in_ready=1, all data outputs, swapped, special = 0.
REQ-027 Reset mid-SHIFT or DONE aborts operation; result discarded, no out_valid pulse.
REQ-028 in_valid sampled while rst_n low is ignored.

Verification
REQ-029 a=0x40000000, b=0x3F800000 -> exp_out=0x80, mant_big=0x4000000, mant_small=0x2000000, swapped=0, out_valid 2 cycles after accept.
REQ-030 a=0x3F800000, b=0x40000000 -> same mantissas/exp_out, swapped=1, sign outputs follow swap.
REQ-031 a=b=0x3F800000 -> k=0, mant_big=mant_small=0x4000000, out_valid 1 cycle after accept; a=0x4B800000, b=0x3F800001 -> k=24, mant_small=0x0000005 (G=1,S=1), latency 25.
REQ-032 a=0x7F000000, b=0x3F800000 -> k clamps to 26, mant_small=0x0000001, latency 27; a=0x7F800000 -> special=1, no shift, latency 1.
REQ-033 out_ready held 0 for 5 cycles in DONE, in_valid pulsed meanwhile -> outputs stable, in_ready=0, pulse ignored; out_ready=1 -> IDLE next cycle.
REQ-034 rst_n low during SHIFT (k=24 case, cycle 10) -> next edge out_valid=0, in_ready=1, outputs 0; new operation after reset completes per REQ-029.
